// File: rtl/cache_lookup_pkg.sv
// Shared types and constants for the cache lookup stage: MESI states, op codes,
// default address-field widths and small helpers.
package cache_lookup_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INDEX_W  = 14;
  localparam int DEF_OFFSET_W = 6;
  localparam int DEF_WAYS     = 8;
  localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

  typedef enum logic [1:0] {I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11} states_t;

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_RESP, ST_WRITE, ST_CLEAR} fsm_t;

  localparam logic [3:0] OP_READ    = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_IFETCH  = 4'd2;
  localparam logic [3:0] OP_SNP_INV = 4'd3;
  localparam logic [3:0] OP_SNP_RD  = 4'd4;
  localparam logic [3:0] OP_CLEAR   = 4'd8;
  localparam logic [3:0] OP_PRINT   = 4'd9;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]   tag;
    logic [DEF_WAYS-2:0]    lru;
    states_t                mesi_bits;
  } cache_line_t;

  // Processor-side ops allocate on miss and age the PLRU tree; snoops do neither.
  function automatic logic is_alloc_op(input logic [3:0] n);
    return n <= OP_IFETCH;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_lookup_plru.sv
// Combinational tree pseudo-LRU for one set: node bit 1 points to the upper half.
module plru_tree #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         bits_nxt,
  output logic [$clog2(WAYS)-1:0] victim
);
  localparam int WAY_W = $clog2(WAYS);

  int node;

  // Heap layout: node k (1-based) lives in bit k-1; the level-l node on the
  // path to a way is indexed by that way's top l bits.
  always_comb begin
    bits_nxt = bits;
    for (int l = 0; l < WAY_W; l++)
      bits_nxt[(1 << l) - 1 + int'(touch_way >> (WAY_W - l))] = ~touch_way[WAY_W-1-l];
  end

  always_comb begin
    node = 1;
    for (int l = 0; l < WAY_W; l++)
      node = 2 * node + int'(bits[node-1]);
    victim = WAY_W'(node - WAYS);
  end

endmodule

// File: rtl/cache_lookup.sv
// Tag/MESI lookup stage ahead of the MESI state machine. Optional macro STATS_EN
// adds saturating read/write/hit/miss counters.
module cache_lookup
  import cache_lookup_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int WAYS     = DEF_WAYS,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_n,
  input  logic [ADDR_W-1:0]       cmd_addr,
  output logic                    line_valid,
  output logic [TAG_W-1:0]        line_tag,
  output states_t                 line_mesi,
  output logic [$clog2(WAYS)-1:0] line_way,
  output logic                    hit,
  output logic                    hitM,
  input  logic                    upd_valid,
  input  states_t                 upd_mesi,
  output logic                    busy_clear
`ifdef STATS_EN
  ,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);
  localparam int SETS  = 2 ** INDEX_W;
  localparam int WAY_W = $clog2(WAYS);

  fsm_t                state, state_nxt;
  logic [3:0]          n_q;
  logic [INDEX_W-1:0]  idx_q, clr_ptr;
  logic [TAG_W-1:0]    tag_q;
  states_t             upd_q;
  logic                do_write, do_plru;

  logic [WAYS-1:0][TAG_W-1:0] tag_mem  [SETS];
  logic [WAYS-1:0][1:0]       mesi_mem [SETS];
  logic [WAYS-2:0]            plru_mem [SETS];

  logic [WAYS-1:0][TAG_W-1:0] set_tag;
  logic [WAYS-1:0][1:0]       set_mesi;
  logic                       hit_any, inv_any;
  logic [WAY_W-1:0]           hit_way, inv_way, victim;
  logic [WAYS-2:0]            plru_nxt;
  logic                       unused_offset;

  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_CLEAR;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cmd_valid) begin
          if (cmd_n <= OP_SNP_RD)     state_nxt = ST_LOOKUP;
          else if (cmd_n == OP_CLEAR) state_nxt = ST_CLEAR;
          else if (cmd_n == OP_PRINT) state_nxt = ST_IDLE;
        end
      ST_LOOKUP: state_nxt = ST_RESP;
      ST_RESP:   if (upd_valid) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = ST_IDLE;
      ST_CLEAR:  if (&clr_ptr) state_nxt = ST_IDLE;
      default:   state_nxt = ST_CLEAR;
    endcase
  end

  // A snoop that missed owns no line, so it leaves the array untouched.
  always_comb begin
    cmd_ready  = state == ST_IDLE;
    line_valid = state == ST_RESP;
    busy_clear = state == ST_CLEAR;
    do_write   = (state == ST_WRITE) && (is_alloc_op(n_q) || hit);
    do_plru    = (state == ST_WRITE) && is_alloc_op(n_q);
  end

  assign set_tag  = tag_mem[idx_q];
  assign set_mesi = mesi_mem[idx_q];

  // Descending scan so the lowest qualifying way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_tag[w] == tag_q && states_t'(set_mesi[w]) != I) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (states_t'(set_mesi[w]) == I) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru_mem[idx_q]),
    .touch_way (line_way),
    .bits_nxt  (plru_nxt),
    .victim    (victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      upd_q     <= I;
      clr_ptr   <= '0;
      line_tag  <= '0;
      line_mesi <= I;
      line_way  <= '0;
      hit       <= 1'b0;
      hitM      <= 1'b0;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        n_q   <= cmd_n;
        idx_q <= cmd_addr[OFFSET_W +: INDEX_W];
        tag_q <= cmd_addr[ADDR_W-1 -: TAG_W];
      end
      if (state == ST_LOOKUP) begin
        line_tag <= tag_q;
        if (hit_any) begin
          line_way  <= hit_way;
          line_mesi <= states_t'(set_mesi[hit_way]);
          hit       <= 1'b1;
          hitM      <= states_t'(set_mesi[hit_way]) == M;
        end else begin
          line_way  <= !is_alloc_op(n_q) ? '0 : (inv_any ? inv_way : victim);
          line_mesi <= I;
          hit       <= 1'b0;
          hitM      <= 1'b0;
        end
      end
      if (state == ST_RESP && upd_valid) upd_q <= upd_mesi;
      if (state == ST_CLEAR)             clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      tag_mem[clr_ptr]  <= '0;
      mesi_mem[clr_ptr] <= {WAYS{I}};
      plru_mem[clr_ptr] <= '0;
    end
    if (do_write) begin
      tag_mem[idx_q][line_way]  <= tag_q;
      mesi_mem[idx_q][line_way] <= upd_q;
    end
    if (do_plru) plru_mem[idx_q] <= plru_nxt;
  end

`ifdef STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == ST_LOOKUP && is_alloc_op(n_q)) begin
      if (n_q == OP_WRITE) stat_writes <= sat_inc(stat_writes);
      else                 stat_reads  <= sat_inc(stat_reads);
      if (hit_any)         stat_hits   <= sat_inc(stat_hits);
      else                 stat_misses <= sat_inc(stat_misses);
    end
  end
`endif

endmodule

// File: tb/tb_cache_lookup.sv
// Randomized self-checking bench for cache_lookup against a per-set array model.
module tb_cache_lookup;
  import cache_lookup_pkg::*;

  localparam int SETS  = 2 ** DEF_INDEX_W;
  localparam int WAYS  = DEF_WAYS;
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = DEF_TAG_W;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, upd_valid = 1'b0;
  logic [3:0] cmd_n = '0;
  logic [DEF_ADDR_W-1:0] cmd_addr = '0;
  states_t upd_mesi = I;
  logic cmd_ready, line_valid, hit, hitM, busy_clear;
  logic [TAG_W-1:0] line_tag;
  states_t line_mesi;
  logic [WAY_W-1:0] line_way;
`ifdef STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;
  int m_reads = 0, m_writes = 0, m_hits = 0, m_misses = 0;
`endif

  cache_lookup dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_addr(cmd_addr), .line_valid(line_valid),
    .line_tag(line_tag), .line_mesi(line_mesi), .line_way(line_way),
    .hit(hit), .hitM(hitM), .upd_valid(upd_valid), .upd_mesi(upd_mesi),
    .busy_clear(busy_clear)
`ifdef STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int total_cnt = 0, pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: contents per set/way plus PLRU node pointers (1 = upper half).
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  states_t          m_st  [SETS][WAYS];
  bit               m_ptr [SETS][WAYS];

  logic             exp_active = 1'b0;
  logic             exp_hit, exp_hitM;
  int               exp_way, m_set;
  states_t          exp_mesi;
  logic [TAG_W-1:0] exp_tag;
  logic [3:0]       m_n;
  logic             m_skip;
  logic             cap_hit, cap_hitM;
  int               cap_way;
  states_t          cap_mesi;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0;
        m_st[s][w]  = I;
        m_ptr[s][w] = 1'b0;
      end
  endtask

  function automatic int plru_victim(input int s);
    int node = 1, lo = 0, span = WAYS;
    while (span > 1) begin
      span = span / 2;
      if (m_ptr[s][node]) begin lo += span; node = 2 * node + 1; end
      else node = 2 * node;
    end
    return lo;
  endfunction

  task automatic plru_touch(input int s, input int way);
    int node = 1, lo = 0, span = WAYS;
    while (span > 1) begin
      span = span / 2;
      if (way < lo + span) begin m_ptr[s][node] = 1'b1; node = 2 * node; end
      else begin m_ptr[s][node] = 1'b0; lo += span; node = 2 * node + 1; end
    end
  endtask

  task automatic model_lookup(input logic [3:0] n, input logic [31:0] addr);
    bit found = 0;
    m_set    = int'(addr[DEF_OFFSET_W +: DEF_INDEX_W]);
    exp_tag  = addr[31 -: TAG_W];
    m_n      = n;
    exp_hit  = 1'b0;
    exp_hitM = 1'b0;
    exp_way  = 0;
    exp_mesi = I;
    for (int w = 0; w < WAYS; w++)
      if (!found && m_tag[m_set][w] == exp_tag && m_st[m_set][w] != I) begin
        found = 1; exp_hit = 1'b1; exp_way = w;
        exp_mesi = m_st[m_set][w]; exp_hitM = (m_st[m_set][w] == M);
      end
    if (!found && n <= OP_IFETCH) begin
      exp_way = plru_victim(m_set);
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_st[m_set][w] == I) exp_way = w;
    end
    m_skip = !exp_hit && n > OP_IFETCH;
`ifdef STATS_EN
    if (n <= OP_IFETCH) begin
      if (n == OP_WRITE) m_writes++; else m_reads++;
      if (exp_hit) m_hits++; else m_misses++;
    end
`endif
    exp_active = 1'b1;
  endtask

  task automatic model_write(input states_t ret);
    if (!m_skip) begin
      m_tag[m_set][exp_way] = exp_tag;
      m_st[m_set][exp_way]  = ret;
    end
    if (m_n <= OP_IFETCH) plru_touch(m_set, exp_way);
  endtask

  // Every RESP cycle the presented line must match the model.
  always @(negedge clk)
    if (rst && exp_active && line_valid) begin
      chk("hit",       32'(hit),       32'(exp_hit));
      chk("hitM",      32'(hitM),      32'(exp_hitM));
      chk("line_way",  32'(line_way),  32'(exp_way));
      chk("line_mesi", 32'(line_mesi), 32'(exp_mesi));
      chk("line_tag",  32'(line_tag),  32'(exp_tag));
    end

  function automatic logic [31:0] mk(input int tag, input int set);
    return (32'(tag) << 20) | (32'(set) << 6);
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    while (busy_clear && cnt < 2 * SETS) begin cnt++; @(negedge clk); end
    chk(name, 32'(cnt), 32'(SETS));
    chk("ready_after_clear", 32'(cmd_ready), 32'd1);
  endtask

  task automatic txn(input logic [3:0] n, input logic [31:0] addr, input int lat, input states_t ret);
    wait_ready();
    model_lookup(n, addr);
    cmd_valid = 1'b1; cmd_n = n; cmd_addr = addr;
    @(negedge clk);
    cmd_valid = 1'($urandom_range(0, 1)); cmd_n = 4'($urandom_range(0, 15)); cmd_addr = $urandom;
    chk("lookup_no_valid", 32'(line_valid), 32'd0);
    chk("lookup_not_ready", 32'(cmd_ready), 32'd0);
    if (lat > 0) begin upd_valid = 1'b1; upd_mesi = states_t'($urandom_range(0, 3)); end
    @(negedge clk);
    chk("latency_valid", 32'(line_valid), 32'd1);
    cap_hit = hit; cap_hitM = hitM; cap_way = int'(line_way); cap_mesi = line_mesi;
    upd_valid = (lat == 0); upd_mesi = ret;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("resp_hold", 32'(line_valid), 32'd1);
      if (i == lat) upd_valid = 1'b1;
    end
    @(negedge clk);
    upd_valid = 1'b0; cmd_valid = 1'b0; upd_mesi = states_t'($urandom_range(0, 3));
    chk("write_no_valid", 32'(line_valid), 32'd0);
    chk("write_not_ready", 32'(cmd_ready), 32'd0);
    exp_active = 1'b0;
    model_write(ret);
    @(negedge clk);
  endtask

  task automatic drop(input logic [3:0] n);
    wait_ready();
    cmd_valid = 1'b1; cmd_n = n; cmd_addr = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("drop_ready", 32'(cmd_ready), 32'd1);
    chk("drop_no_valid", 32'(line_valid), 32'd0);
    chk("drop_no_clear", 32'(busy_clear), 32'd0);
  endtask

  initial begin
    int r, lat, set, tag;
    logic [3:0] n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hitM", 32'(hitM), 32'd0);
    chk("rst_line_tag", 32'(line_tag), 32'd0);
    chk("rst_line_mesi", 32'(line_mesi), 32'(I));
    chk("rst_line_way", 32'(line_way), 32'd0);
    chk("rst_busy_clear", 32'(busy_clear), 32'd1);
    rst = 1'b1;
    wait_clear("init_clear_cycles");
    model_clear();

    txn(OP_READ, 32'h0000_1040, 1, E);
    chk("lit_first_hit", 32'(cap_hit), 32'd0);
    chk("lit_first_way", 32'(cap_way), 32'd0);
    chk("lit_first_mesi", 32'(cap_mesi), 32'(I));
    txn(OP_READ, 32'h0000_1040, 0, E);
    chk("lit_reread_hit", 32'(cap_hit), 32'd1);
    chk("lit_reread_hitM", 32'(cap_hitM), 32'd0);
    chk("lit_reread_mesi", 32'(cap_mesi), 32'(E));
    txn(OP_WRITE, 32'h0000_1040, 2, M);
    txn(OP_SNP_RD, 32'h0000_1040, 0, S);
    chk("lit_snoop_hit", 32'(cap_hit), 32'd1);
    chk("lit_snoop_hitM", 32'(cap_hitM), 32'd1);
    for (int t = 1; t < WAYS; t++) begin
      txn(OP_READ, mk(t, 'h41), int'($urandom_range(0, 2)), E);
      chk("lit_fill_way", 32'(cap_way), 32'(t));
    end
    txn(OP_SNP_INV, mk(9, 'h41), 1, I);
    chk("lit_sinv_hit", 32'(cap_hit), 32'd0);
    chk("lit_sinv_mesi", 32'(cap_mesi), 32'(I));
    txn(OP_READ, mk(8, 'h41), 0, E);
    chk("lit_victim_hit", 32'(cap_hit), 32'd0);
    chk("lit_victim_way", 32'(cap_way), 32'd0);
    txn(OP_READ, mk(8, 'h41), 1, S);
    chk("lit_victim_rehit", 32'(cap_hit), 32'd1);
    chk("lit_victim_mesi", 32'(cap_mesi), 32'(E));
    txn(OP_READ, mk(3, 'h41), 0, E);
    chk("lit_way3_way", 32'(cap_way), 32'd3);
    drop(OP_PRINT);
    drop(4'd5);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 17) drop(OP_PRINT);
      else if (r == 18) drop($urandom_range(0, 1) ? 4'($urandom_range(5, 7)) : 4'($urandom_range(10, 15)));
      else begin
        n = (r < 6) ? OP_READ : (r < 10) ? OP_WRITE : (r < 12) ? OP_IFETCH :
            (r < 15) ? OP_SNP_RD : (r < 17) ? OP_SNP_INV : OP_READ;
        set = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS - 1)) : 'h41 + int'($urandom_range(0, 1));
        tag = int'($urandom_range(0, 11));
        lat = int'($urandom_range(0, 3));
        txn(n, mk(tag, set), lat, states_t'($urandom_range(0, 3)));
      end
    end

`ifdef STATS_EN
    chk("stat_reads", stat_reads, 32'(m_reads));
    chk("stat_writes", stat_writes, 32'(m_writes));
    chk("stat_hits", stat_hits, 32'(m_hits));
    chk("stat_misses", stat_misses, 32'(m_misses));
`endif

    wait_ready();
    cmd_valid = 1'b1; cmd_n = OP_CLEAR; cmd_addr = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_clear("cmd_clear_cycles");
    model_clear();
    txn(OP_READ, 32'h0000_1040, 0, E);
    chk("lit_after_clear_hit", 32'(cap_hit), 32'd0);

    wait_ready();
    model_lookup(OP_READ, mk('h55, 'h200));
    cmd_valid = 1'b1; cmd_n = OP_READ; cmd_addr = mk('h55, 'h200);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_resp", 32'(line_valid), 32'd1);
    upd_valid = 1'b1; upd_mesi = M;
    rst = 1'b0;
    exp_active = 1'b0;
    #1;
    chk("rst_mid_line_valid", 32'(line_valid), 32'd0);
    chk("rst_mid_hit", 32'(hit), 32'd0);
    chk("rst_mid_line_tag", 32'(line_tag), 32'd0);
    chk("rst_mid_line_way", 32'(line_way), 32'd0);
    chk("rst_mid_line_mesi", 32'(line_mesi), 32'(I));
    chk("rst_mid_busy", 32'(busy_clear), 32'd1);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
    upd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    wait_clear("rst_clear_cycles");
    model_clear();
`ifdef STATS_EN
    m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
`endif
    txn(OP_READ, mk('h55, 'h200), 1, E);
    chk("lit_rst_discard_hit", 32'(cap_hit), 32'd0);
    chk("lit_rst_discard_mesi", 32'(cap_mesi), 32'(I));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
